ripple_carry_adder_sync: RTL and testbench



---
 rtl/rca_pkg.sv | 12 +
 rtl/ripple_carry_adder_sync_full_adder.sv | 16 +
 rtl/ripple_carry_adder_sync.sv | 88 ++++++++
 tb/tb_ripple_carry_adder_sync.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the registered ripple-carry adder: default width and
// the {carry, sum} result view used when checking the adder's full result.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                         carry;
    logic [RCA_DEFAULT_WIDTH-1:0] sum;
  } rca_result_t;

endpackage : rca_pkg

// File: rtl/ripple_carry_adder_sync_full_adder.sv
// One-bit full adder: the single stage replicated along the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (w_p & ci);

endmodule : full_adder

// File: rtl/ripple_carry_adder_sync.sv
// Registered WIDTH-bit ripple-carry adder exposing every stage carry-out.
// Optional feature: define RCA_OVF_EN to add the registered signed-overflow output ovf.
module ripple_carry_adder_sync
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] cout,
  output logic             out_valid
`ifdef RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_cout;

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_cout;
  logic             r_valid;

  // Each stage keeps its own carry nets so the chain is a plain series of
  // distinct wires rather than one vector feeding back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
    logic w_ci;
    logic w_co;

    if (i == 0) begin : gen_first
      assign w_ci = cin;
    end else begin : gen_rest
      assign w_ci = gen_fa[i-1].w_co;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_ci),
      .s  (w_sum[i]),
      .co (w_co)
    );

    assign w_cout[i] = w_co;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_cout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign out_valid = r_valid;

`ifdef RCA_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_cout[WIDTH-1] ^ w_cout[WIDTH-2];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : ripple_carry_adder_sync

// File: tb/tb_ripple_carry_adder_sync.sv
// Directed self-checking bench for ripple_carry_adder_sync at WIDTH=4.
// Covers async reset, the hand-computed vectors, hold on idle and toggling valid.
module tb_ripple_carry_adder_sync;
  import rca_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic [W-1:0] cout;
  logic         out_valid;
`ifdef RCA_OVF_EN
  logic         ovf;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;

  ripple_carry_adder_sync #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef RCA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hand-computed vectors: a, b, cin -> s, cout, full result, signed overflow.
  logic [W-1:0] v_a    [5] = '{4'h1, 4'h2, 4'hB, 4'h5, 4'hF};
  logic [W-1:0] v_b    [5] = '{4'h0, 4'h4, 4'h6, 4'h3, 4'hF};
  logic         v_cin  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] v_s    [5] = '{4'b0001, 4'b0111, 4'b0001, 4'b1001, 4'b1111};
  logic [W-1:0] v_cout [5] = '{4'b0000, 4'b0000, 4'b1110, 4'b0111, 4'b1111};
  int           v_res  [5] = '{1, 7, 17, 9, 31};
  logic         v_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic check_outputs(input string tag, input logic [W-1:0] es,
                               input logic [W-1:0] ec, input logic ev);
    check({tag, ".s"},         32'(s),         32'(es));
    check({tag, ".cout"},      32'(cout),      32'(ec));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    rca_result_t res;
    logic [W-1:0] last_s;
    logic [W-1:0] last_c;
`ifdef RCA_OVF_EN
    logic last_ovf;
`endif

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #1;
    check_outputs("por", '0, '0, 1'b0);

    // Leave reset and load a non-zero result so the async clear is observable.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
    @(posedge clk); #1;
    check_outputs("preload", 4'hF, 4'hF, 1'b1);

    // Async assert mid-cycle: outputs clear before any clock edge.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async", '0, '0, 1'b0);
`ifdef RCA_OVF_EN
    check("rst_async.ovf", 32'(ovf), 32'(0));
`endif
    // Valid inputs during reset must not leak through.
    @(posedge clk); #1;
    check_outputs("rst_held", '0, '0, 1'b0);

    // Release mid-cycle with no valid input: still nothing emitted.
    @(negedge clk); #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_outputs("rst_release", '0, '0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = v_a[i]; b = v_b[i]; cin = v_cin[i];
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), v_s[i], v_cout[i], 1'b1);
      res = '{carry: cout[W-1], sum: s};
      check($sformatf("vec%0d.result", i), 32'(res), 32'(v_res[i]));
`ifdef RCA_OVF_EN
      check($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(v_ovf[i]));
`endif
      // Odd vectors are followed by an idle cycle (valid toggling); even ones
      // run back-to-back into the next vector.
      if (i % 2 == 1 || i == 4) begin
        last_s = v_s[i];
        last_c = v_cout[i];
`ifdef RCA_OVF_EN
        last_ovf = v_ovf[i];
`endif
        @(negedge clk);
        in_valid = 1'b0; a = 4'h3; b = 4'h9; cin = 1'b0;
        @(posedge clk); #1;
        check_outputs($sformatf("hold%0d", i), last_s, last_c, 1'b0);
`ifdef RCA_OVF_EN
        check($sformatf("hold%0d.ovf", i), 32'(ovf), 32'(last_ovf));
`endif
      end
    end

    // Second idle cycle: values keep holding.
    @(posedge clk); #1;
    check_outputs("hold_long", 4'hF, 4'hF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_ripple_carry_adder_sync
